// File: rtl/hf_pkg.sv
// Shared definitions for the HF subcarrier demodulator: timestamp FSM encoding
// and subcarrier mode constants.
package hf_pkg;

    localparam int unsigned SC_LOG2_848K = 4;
    localparam int unsigned SC_LOG2_424K = 5;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_PAUSE = 2'd1,
        TS_COUNT = 2'd2,
        TS_DONE  = 2'd3
    } ts_state_e;

endpackage

// File: rtl/hf_edge_filter.sv
// Edge filter over a 4-deep ADC history plus per-window extreme tracking;
// decides whether the last window saw both a strong fall and a strong rise.
module hf_edge_filter
    import hf_pkg::*;
#(
    parameter int unsigned ADC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             decide,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [ADC_W+2:0] threshold,
    output logic             curbit
);

    localparam int unsigned F_W = ADC_W + 3;
    localparam int unsigned C_W = ADC_W + 4;

    logic [ADC_W-1:0]      x1, x2, x3, x4;
    logic signed [F_W-1:0] fall_max, rise_min;

    logic [F_W-1:0]        pos_c, neg_c;
    logic signed [F_W-1:0] f_c;
    logic                  f_pos_c;
    logic signed [C_W-1:0] fall_ext_c, rise_ext_c, thr_pos_c, thr_neg_c;

    // One extra bit keeps -threshold and the extremes comparable without overflow.
    always_comb begin
        pos_c      = F_W'({x4, 1'b0}) + F_W'(x3);
        neg_c      = F_W'({adc_d, 1'b0}) + F_W'(x1);
        f_c        = $signed(pos_c - neg_c);
        f_pos_c    = !f_c[F_W-1] && (f_c != '0);
        fall_ext_c = {fall_max[F_W-1], fall_max};
        rise_ext_c = {rise_min[F_W-1], rise_min};
        thr_pos_c  = $signed({1'b0, threshold});
        thr_neg_c  = -thr_pos_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1       <= '0;
            x2       <= '0;
            x3       <= '0;
            x4       <= '0;
            fall_max <= '0;
            rise_min <= '0;
            curbit   <= 1'b0;
        end else if (!enable) begin
            x1       <= '0;
            x2       <= '0;
            x3       <= '0;
            x4       <= '0;
            fall_max <= '0;
            rise_min <= '0;
            curbit   <= 1'b0;
        end else begin
            x1 <= adc_d;
            x2 <= x1;
            x3 <= x2;
            x4 <= x3;
            if (decide) begin
                curbit   <= (fall_ext_c > thr_pos_c) && (rise_ext_c < thr_neg_c);
                fall_max <= '0;
                rise_min <= '0;
            end else if (f_pos_c) begin
                if (f_c > fall_max) fall_max <= f_c;
            end else begin
                if (f_c < rise_min) rise_min <= f_c;
            end
        end
    end

endmodule

// File: rtl/hf_subcarrier_demod.sv
// HF tag subcarrier demodulator: window-based edge detector, SSP serialiser
// and reader-pause-to-response latency timestamp.
module hf_subcarrier_demod
    import hf_pkg::*;
#(
    parameter int unsigned ADC_W      = 8,
    parameter int unsigned SC_LOG2    = SC_LOG2_848K,
    parameter int unsigned RST_PHASE  = 3,
    parameter int unsigned FRAME_BITS = 8,
    parameter int unsigned TS_W       = 16
) (
    input  logic             ck_1356meg,
    input  logic             nrst,
    input  logic             enable,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [ADC_W+2:0] threshold,
    input  logic             mod_sig_coil,
    output logic             curbit,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic [TS_W-1:0]  ts_value,
    output logic             ts_valid,
    output logic             ts_ovf
);

    localparam int unsigned BC_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [SC_LOG2-1:0] PH_LAST = '1;
    localparam logic [SC_LOG2-1:0] PH_DEC  = SC_LOG2'(RST_PHASE);
    localparam logic [BC_W-1:0]    BC_LAST = BC_W'(FRAME_BITS - 1);
    localparam logic [TS_W-1:0]    TS_MAX  = '1;

    logic [SC_LOG2-1:0] phase;
    logic [BC_W-1:0]    bitcnt;
    logic [TS_W-1:0]    ts_cnt;
    logic               curbit_d;
    ts_state_e          ts_state;

    logic [SC_LOG2-1:0] phase_nxt_c;
    logic [BC_W-1:0]    bitcnt_nxt_c;
    logic               decide_c;
    logic               curbit_rise_c;

    always_comb begin
        phase_nxt_c   = phase + SC_LOG2'(1);
        bitcnt_nxt_c  = (bitcnt == BC_LAST) ? '0 : bitcnt + BC_W'(1);
        decide_c      = (phase == PH_DEC);
        curbit_rise_c = curbit && !curbit_d;
    end

    hf_edge_filter #(
        .ADC_W(ADC_W)
    ) u_filter (
        .clk      (ck_1356meg),
        .rst_n    (nrst),
        .enable   (enable),
        .decide   (decide_c),
        .adc_d    (adc_d),
        .threshold(threshold),
        .curbit   (curbit)
    );

    // ssp_clk/ssp_din/ssp_frame are computed from the next phase so they line up with phase itself.
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            phase     <= '0;
            bitcnt    <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
            curbit_d  <= 1'b0;
            ts_state  <= TS_IDLE;
            ts_cnt    <= '0;
            ts_value  <= '0;
            ts_valid  <= 1'b0;
            ts_ovf    <= 1'b0;
        end else if (!enable) begin
            phase     <= '0;
            bitcnt    <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
            curbit_d  <= 1'b0;
            ts_state  <= TS_IDLE;
            ts_cnt    <= '0;
            ts_value  <= '0;
            ts_valid  <= 1'b0;
            ts_ovf    <= 1'b0;
        end else begin
            phase    <= phase_nxt_c;
            ssp_clk  <= !phase_nxt_c[SC_LOG2-1];
            curbit_d <= curbit;
            ts_valid <= 1'b0;
            if (phase == PH_LAST) begin
                ssp_din   <= curbit;
                bitcnt    <= bitcnt_nxt_c;
                ssp_frame <= (bitcnt_nxt_c == '0);
            end
            // A new reader pause always wins over a coincident tag response.
            unique case (ts_state)
                TS_IDLE: begin
                    if (mod_sig_coil) ts_state <= TS_PAUSE;
                end
                TS_PAUSE: begin
                    if (!mod_sig_coil) begin
                        ts_state <= TS_COUNT;
                        ts_cnt   <= '0;
                    end
                end
                TS_COUNT: begin
                    if (mod_sig_coil) begin
                        ts_state <= TS_PAUSE;
                    end else if (curbit_rise_c) begin
                        ts_state <= TS_DONE;
                        ts_value <= ts_cnt;
                        ts_valid <= 1'b1;
                    end else if (ts_cnt == TS_MAX) begin
                        ts_state <= TS_DONE;
                        ts_value <= TS_MAX;
                        ts_valid <= 1'b1;
                        ts_ovf   <= 1'b1;
                    end else begin
                        ts_cnt <= ts_cnt + TS_W'(1);
                    end
                end
                TS_DONE: begin
                    if (mod_sig_coil) begin
                        ts_state <= TS_PAUSE;
                        ts_ovf   <= 1'b0;
                    end
                end
                default: ts_state <= TS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hf_subcarrier_demod.sv
// Directed scoreboard bench for hf_subcarrier_demod: default, short-timestamp
// and 424 kHz instances on one carrier clock.
module tb_hf_subcarrier_demod;
    import hf_pkg::*;

    logic        ck_1356meg = 1'b0;
    logic        nrst, enable, mod_sig_coil, mod_t;
    logic [7:0]  adc_d, adc_t;
    logic [10:0] threshold;

    logic        curbit, ssp_clk, ssp_frame, ssp_din, ts_valid, ts_ovf;
    logic [15:0] ts_value;
    logic        curbit_t, ssp_clk_t, ssp_frame_t, ssp_din_t, ts_valid_t, ts_ovf_t;
    logic [5:0]  ts_value_t;
    logic        curbit_s, ssp_clk_s, ssp_frame_s, ssp_din_s, ts_valid_s, ts_ovf_s;
    logic [15:0] ts_value_s;

    always #5 ck_1356meg = ~ck_1356meg;

    hf_subcarrier_demod dut (
        .ck_1356meg(ck_1356meg), .nrst(nrst), .enable(enable), .adc_d(adc_d),
        .threshold(threshold), .mod_sig_coil(mod_sig_coil), .curbit(curbit),
        .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din),
        .ts_value(ts_value), .ts_valid(ts_valid), .ts_ovf(ts_ovf));

    hf_subcarrier_demod #(.TS_W(6)) dut_ts (
        .ck_1356meg(ck_1356meg), .nrst(nrst), .enable(enable), .adc_d(adc_t),
        .threshold(threshold), .mod_sig_coil(mod_t), .curbit(curbit_t),
        .ssp_clk(ssp_clk_t), .ssp_frame(ssp_frame_t), .ssp_din(ssp_din_t),
        .ts_value(ts_value_t), .ts_valid(ts_valid_t), .ts_ovf(ts_ovf_t));

    hf_subcarrier_demod #(.SC_LOG2(SC_LOG2_424K), .FRAME_BITS(4)) dut_sc (
        .ck_1356meg(ck_1356meg), .nrst(nrst), .enable(enable), .adc_d(adc_d),
        .threshold(threshold), .mod_sig_coil(mod_sig_coil), .curbit(curbit_s),
        .ssp_clk(ssp_clk_s), .ssp_frame(ssp_frame_s), .ssp_din(ssp_din_s),
        .ts_value(ts_value_s), .ts_valid(ts_valid_s), .ts_ovf(ts_ovf_s));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int cyc = 0, sq_k = 0, vcnt = 0, vcnt_t = 0, cb_hi = 0, din_lo = 0;
    int clk_hi = 0, fr_hi = 0, clk_hi_s = 0, fr_hi_s = 0;
    int last_rise_s = -1, period_s = 0;
    logic sq_on = 1'b0, prev_clk_s = 1'b0;

    function automatic void push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endfunction

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed %0d, required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s: observed %0d, required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance n cycles: sample outputs at the falling edge, then drive the square wave.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge ck_1356meg);
            cyc++;
            if (ts_valid)   vcnt++;
            if (ts_valid_t) vcnt_t++;
            if (curbit)     cb_hi++;
            if (!ssp_din)   din_lo++;
            if (ssp_clk)    clk_hi++;
            if (ssp_frame)  fr_hi++;
            if (ssp_clk_s)  clk_hi_s++;
            if (ssp_frame_s) fr_hi_s++;
            if (ssp_clk_s && !prev_clk_s) begin
                if (last_rise_s >= 0) period_s = cyc - last_rise_s;
                last_rise_s = cyc;
            end
            prev_clk_s = ssp_clk_s;
            if (sq_on) begin
                adc_d = sq_k[3] ? 8'd200 : 8'd0;
                sq_k++;
            end
        end
    endtask

    task automatic wait_curbit(input int limit, output int took);
        took = -1;
        for (int i = 0; i < limit; i++) begin
            if (curbit) begin
                took = i;
                break;
            end
            run(1);
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        run(2);
        nrst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   took, base, base2, found;
        logic pclk;

        nrst = 1'b0; enable = 1'b1; adc_d = 8'd0; adc_t = 8'd128;
        threshold = 11'd40; mod_sig_coil = 1'b0; mod_t = 1'b0;
        run(2);
        push("reset_outputs", 32'd0);
        check(32'({curbit, ssp_clk, ssp_frame, ssp_din, ts_valid, ts_ovf}));
        push("reset_ts_value", 32'd0);
        check(32'(ts_value));
        push("reset_state", 32'(TS_IDLE));
        check(32'(dut.ts_state));

        // Constant input: no edges, no bit.
        adc_d = 8'd128;
        nrst = 1'b1;
        base = cb_hi; base2 = din_lo;
        run(96);
        push("const_curbit_low", 32'd0);
        check(32'(cb_hi - base));
        push("const_ssp_din_low", 32'd96);
        check(32'(din_lo - base2));

        // Single rising step: only one edge direction, still no bit.
        adc_d = 8'd0;
        do_reset();
        run(40);
        base = cb_hi;
        adc_d = 8'd200;
        run(96);
        push("step_curbit_low", 32'd0);
        check(32'(cb_hi - base));

        // Square wave 0/200, period 16, threshold 40.
        do_reset();
        sq_k = 8; sq_on = 1'b1;
        wait_curbit(40, took);
        push("square_curbit_within_2win", 32'd1);
        check(32'(took >= 0));
        found = 0;
        pclk = ssp_clk;
        for (int i = 0; i < 20; i++) begin
            if (ssp_din) begin
                found = 1;
                break;
            end
            pclk = ssp_clk;
            run(1);
        end
        push("square_ssp_din_set", 32'd1);
        check(32'(found));
        push("ssp_din_at_phase0", 32'd1);
        check(32'({pclk, ssp_clk}));
        base = din_lo; base2 = clk_hi; took = fr_hi;
        run(256);
        push("square_ssp_din_held", 32'd0);
        check(32'(din_lo - base));
        push("ssp_clk_high_848k", 32'd128);
        check(32'(clk_hi - base2));
        push("ssp_frame_high_848k", 32'd32);
        check(32'(fr_hi - took));

        // Threshold boundary: peak |f| is exactly 600.
        threshold = 11'd600;
        run(48);
        base = cb_hi;
        run(64);
        push("thr600_curbit_low", 32'd0);
        check(32'(cb_hi - base));
        threshold = 11'd599;
        wait_curbit(48, took);
        push("thr599_curbit_high", 32'd1);
        check(32'(took >= 0));

        // Pause then tag response 100 cycles later.
        sq_on = 1'b0; adc_d = 8'd128; threshold = 11'd40;
        do_reset();
        run(20);
        base = vcnt;
        mod_sig_coil = 1'b1;
        run(10);
        mod_sig_coil = 1'b0;
        run(100);
        sq_k = 0; sq_on = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (vcnt != base) break;
            run(1);
        end
        run(64);
        push("latency_valid_once", 32'd1);
        check(32'(vcnt - base));
        push("latency_value_in_range", 32'd1);
        check(32'((ts_value >= 16'd100) && (ts_value <= 16'd148)));
        push("latency_ovf_low", 32'd0);
        check(32'(ts_ovf));
        push("latency_state_done", 32'(TS_DONE));
        check(32'(dut.ts_state));

        // 6-bit timestamp with no tag response saturates.
        base = vcnt_t;
        mod_t = 1'b1;
        run(5);
        mod_t = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (vcnt_t != base) break;
            run(1);
        end
        run(20);
        push("ovf_value", 32'd63);
        check(32'(ts_value_t));
        push("ovf_flag", 32'd1);
        check(32'(ts_ovf_t));
        push("ovf_valid_once", 32'd1);
        check(32'(vcnt_t - base));
        mod_t = 1'b1;
        run(2);
        push("ovf_cleared_on_pause", 32'd0);
        check(32'(ts_ovf_t));
        push("ovf_value_held", 32'd63);
        check(32'(ts_value_t));
        mod_t = 1'b0;

        // 424 kHz mode with 4-bit frames.
        run(40);
        push("ssp_clk_period_424k", 32'd32);
        check(32'(period_s));
        base = clk_hi_s; base2 = fr_hi_s;
        run(256);
        push("ssp_clk_high_424k", 32'd128);
        check(32'(clk_hi_s - base));
        push("ssp_frame_high_424k", 32'd64);
        check(32'(fr_hi_s - base2));

        // Disable clears outputs and state while a result is held.
        enable = 1'b0;
        run(3);
        push("disable_outputs", 32'd0);
        check(32'({curbit, ssp_clk, ssp_frame, ssp_din, ts_valid, ts_ovf}));
        push("disable_ts_value", 32'd0);
        check(32'(ts_value));
        push("disable_state", 32'(TS_IDLE));
        check(32'(dut.ts_state));
        enable = 1'b1;

        // Reset in the middle of COUNT.
        sq_on = 1'b0; adc_d = 8'd128;
        run(40);
        mod_sig_coil = 1'b1;
        run(3);
        mod_sig_coil = 1'b0;
        run(20);
        push("precondition_count", 32'(TS_COUNT));
        check(32'(dut.ts_state));
        base = vcnt;
        do_reset();
        sq_k = 0; sq_on = 1'b1;
        run(80);
        push("reset_mid_count_no_valid", 32'd0);
        check(32'(vcnt - base));
        push("reset_mid_count_idle", 32'(TS_IDLE));
        check(32'(dut.ts_state));

        // Second pause in the middle of COUNT.
        sq_on = 1'b0; adc_d = 8'd128;
        run(40);
        mod_sig_coil = 1'b1;
        run(3);
        mod_sig_coil = 1'b0;
        run(20);
        base = vcnt;
        mod_sig_coil = 1'b1;
        run(5);
        sq_k = 0; sq_on = 1'b1;
        run(80);
        push("repause_no_valid", 32'd0);
        check(32'(vcnt - base));
        push("repause_state_pause", 32'(TS_PAUSE));
        check(32'(dut.ts_state));
        mod_sig_coil = 1'b0;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
